// File: rtl/uc_multiciclo_if.sv
// Memory handshake bundle between the multicycle control unit and the
// instruction/data memories.
interface uc_multiciclo_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for an RV64I core: sequences fetch, decode,
// execute, memory and write-back, keeps a retired-instruction counter and a
// sticky illegal-instruction flag.
//
//  state  | meaning
//  FETCH  | request instruction, load IR on imem_ready
//  DECODE | classify opcode, unsupported -> HALT
//  EXEC   | ALU operation; branches/jumps update PC here
//  MEM    | data memory access, hold until dmem_ready
//  WB     | register-file write, PC <- PC+4
//  HALT   | illegal instruction seen, idle until reset
module uc_multiciclo #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  uc_multiciclo_if.master  mem,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             ir_load,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic [2:0]       imm_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                         ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                         ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  state_t            state_q, state_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, supported;
  logic [3:0] alu_op_x;
  logic       src_a_x, src_b_x;
  logic [2:0] imm_x;

  // Opcode classification and immediate format
  always_comb begin
    is_lui    = (opcode == 7'b0110111);
    is_auipc  = (opcode == 7'b0010111);
    is_jal    = (opcode == 7'b1101111);
    is_jalr   = (opcode == 7'b1100111);
    is_branch = (opcode == 7'b1100011);
    is_load   = (opcode == 7'b0000011);
    is_store  = (opcode == 7'b0100011);
    is_opimm  = (opcode == 7'b0010011);
    is_op     = (opcode == 7'b0110011);
    supported = is_lui | is_auipc | is_jal | is_load | is_store | is_opimm | is_op
              | (is_jalr & (funct3 == 3'b000))
              | (is_branch & ((funct3 == 3'b000) | (funct3 == 3'b001)));
    imm_x = 3'd0;
    if (is_store)              imm_x = 3'd1;
    else if (is_branch)        imm_x = 3'd2;
    else if (is_lui | is_auipc) imm_x = 3'd3;
    else if (is_jal)           imm_x = 3'd4;
  end

  // ALU operation and operand selects for the current instruction
  always_comb begin
    alu_op_x = ALU_ADD;
    src_a_x  = 1'b0;
    src_b_x  = 1'b0;
    if (is_op | is_opimm) begin
      src_b_x = is_opimm;
      case (funct3)
        3'b000: alu_op_x = (is_op & funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op_x = ALU_SLL;
        3'b010: alu_op_x = ALU_SLT;
        3'b011: alu_op_x = ALU_SLTU;
        3'b100: alu_op_x = ALU_XOR;
        3'b101: alu_op_x = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_op_x = ALU_OR;
        default: alu_op_x = ALU_AND;
      endcase
    end else if (is_lui) begin
      src_b_x  = 1'b1;
      alu_op_x = ALU_PASSB;
    end else if (is_auipc) begin
      src_a_x = 1'b1;
      src_b_x = 1'b1;
    end else if (is_load | is_store | is_jalr) begin
      src_b_x = 1'b1;
    end else if (is_branch) begin
      alu_op_x = ALU_SUB;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    imm_sel      = 3'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel = imm_x;
        if (supported) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        imm_sel   = imm_x;
        alu_op    = alu_op_x;
        alu_src_a = src_a_x;
        alu_src_b = src_b_x;
        if (is_op | is_opimm | is_lui | is_auipc) begin
          state_d = S_WB;
        end else if (is_load | is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_load = 1'b1;
          pc_src  = (((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero)) ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (is_jal | is_jalr) begin
          pc_load = 1'b1;
          pc_src  = is_jalr ? 2'd2 : 2'd1;
          rf_we   = 1'b1;
          wb_sel  = 2'd2;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        imm_sel      = imm_x;
        alu_src_b    = 1'b1;
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_store;
        if (mem.dmem_ready) begin
          if (is_store) begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        imm_sel   = imm_x;
        alu_op    = alu_op_x;
        alu_src_a = src_a_x;
        alu_src_b = src_b_x;
        rf_we     = 1'b1;
        wb_sel    = is_load ? 2'd1 : 2'd0;
        pc_load   = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    // Requests and enables must vanish the moment reset rises, not at the next edge.
    if (reset) begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      ir_load      = 1'b0;
      pc_load      = 1'b0;
      rf_we        = 1'b0;
    end
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, pc_load};
  end

  // State, sticky flag and retired-instruction counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for the multicycle control unit: a table of instructions
// with expected EXEC-cycle controls, plus hand sequences for reset during
// memory access, fetch/data wait states and illegal instructions.
module tb_uc_multiciclo;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        ir_load, pc_load, alu_src_a, alu_src_b, rf_we, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  imm_sel, state;
  logic [63:0] instret;

  uc_multiciclo_if mif ();

  uc_multiciclo #(.CNT_W(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem      (mif),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .zero     (zero),
    .ir_load  (ir_load),
    .pc_load  (pc_load),
    .pc_src   (pc_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op   (alu_op),
    .imm_sel  (imm_sel),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .illegal  (illegal),
    .state    (state),
    .instret  (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [3:0] alu;
    logic       sa;
    logic       sb;
    logic       pcl;
    logic [1:0] pcs;
    logic       rfw;
    logic [1:0] wbs;
    logic [2:0] imm;
    logic [2:0] nxt;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  longint      exp_instret = 0;
  vec_t        vecs[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One instruction from fetch to return into FETCH, with fw fetch wait
  // cycles and mw data-memory wait cycles.
  task automatic run_vec(input vec_t v, input int fw, input int mw);
    int   cyc;
    int   lat;
    int   mk;
    bit   done;
    bit   first;
    logic is_ld, is_st, rdy;
    is_ld = (v.op == 7'b0000011);
    is_st = (v.op == 7'b0100011);
    cyc = 0;
    mk = 0;
    done = 0;
    first = 1;
    for (int i = 0; i <= fw; i++) begin
      @(negedge clk);
      opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; zero = v.z;
      mif.imem_ready = (i == fw);
      mif.dmem_ready = 1'b0;
      #1;
      chk("fetch_imem_req", mif.imem_req, 1);
      chk("fetch_ir_load", ir_load, (i == fw));
      cyc++;
    end
    @(negedge clk);
    mif.imem_ready = 1'b0;
    #1;
    chk("decode_state", state, 1);
    chk("decode_imm_sel", imm_sel, v.imm);
    cyc++;
    @(negedge clk);
    #1;
    chk("exec_state", state, 2);
    chk("exec_alu_op", alu_op, v.alu);
    chk("exec_src_a", alu_src_a, v.sa);
    chk("exec_src_b", alu_src_b, v.sb);
    chk("exec_pc_load", pc_load, v.pcl);
    if (v.pcl) chk("exec_pc_src", pc_src, v.pcs);
    chk("exec_rf_we", rf_we, v.rfw);
    if (v.rfw) chk("exec_wb_sel", wb_sel, v.wbs);
    chk("exec_imm_sel", imm_sel, v.imm);
    chk("exec_dmem_req", mif.dmem_req, 0);
    cyc++;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      #1;
      if (first) begin
        chk("exec_next_state", state, v.nxt);
        first = 0;
      end
      if (state == 3'd0) begin
        done = 1;
      end else if (state == 3'd3) begin
        rdy = (mk == mw);
        mif.dmem_ready = rdy;
        #1;
        chk("mem_dmem_req", mif.dmem_req, 1);
        chk("mem_dmem_we", mif.dmem_we, is_st);
        chk("mem_pc_load", pc_load, is_st & rdy);
        chk("mem_rf_we", rf_we, 0);
        mk++;
        cyc++;
      end else if (state == 3'd4) begin
        mif.dmem_ready = 1'b0;
        #1;
        chk("wb_rf_we", rf_we, 1);
        chk("wb_wb_sel", wb_sel, is_ld ? 2'd1 : 2'd0);
        chk("wb_pc_load", pc_load, 1);
        chk("wb_pc_src", pc_src, 0);
        cyc++;
      end else begin
        cyc++;
      end
    end
    mif.dmem_ready = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL return_to_fetch: got state %0d expected 0 within 20 cycles", state);
    end
    lat = 3 + fw;
    if (v.nxt == 3'd4) lat = lat + 1;
    if (v.nxt == 3'd3) lat = lat + (is_ld ? 2 : 1) + mw;
    chk("latency", cyc, lat);
    exp_instret++;
    chk("instret", instret, exp_instret);
    chk("illegal_clear", illegal, 0);
  endtask

  task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7_5 = 1'b0; zero = 1'b0;
    mif.imem_ready = 1'b1;
    #1;
    chk("ill_fetch_ir_load", ir_load, 1);
    @(negedge clk);
    mif.imem_ready = 1'b0;
    #1;
    chk("ill_decode_state", state, 1);
    chk("ill_decode_illegal", illegal, 0);
    @(negedge clk);
    #1;
    chk("ill_halt_state", state, 5);
    chk("ill_flag", illegal, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mif.imem_ready = 1'b1;
      mif.dmem_ready = 1'b1;
      #1;
      chk("halt_pc_load", pc_load, 0);
      chk("halt_imem_req", mif.imem_req, 0);
      chk("halt_state", state, 5);
    end
    chk("halt_instret", instret, exp_instret);
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_instret = 0;
    chk("rst_illegal", illegal, 0);
    chk("rst_state", state, 0);
    chk("rst_instret", instret, exp_instret);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_imem_req", mif.imem_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op          f3      f7    z     alu    sa    sb    pcl   pcs    rfw   wbs    imm    nxt
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // ADD
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SUB
    vecs[2]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SLL
    vecs[3]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SLT
    vecs[4]  = '{7'b0110011, 3'b011, 1'b0, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SLTU
    vecs[5]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // XOR
    vecs[6]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SRL
    vecs[7]  = '{7'b0110011, 3'b101, 1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SRA
    vecs[8]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // OR
    vecs[9]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // AND
    vecs[10] = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // ADDI f7=1
    vecs[11] = '{7'b0010011, 3'b101, 1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SRAI
    vecs[12] = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd4}; // SLTI
    vecs[13] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd3, 3'd4}; // LUI
    vecs[14] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd3, 3'd4}; // AUIPC
    vecs[15] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd3}; // LW
    vecs[16] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd1, 3'd3}; // SW
    vecs[17] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 3'd2, 3'd0}; // BEQ taken
    vecs[18] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd2, 3'd0}; // BNE not taken
    vecs[19] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd2, 3'd0}; // BEQ not taken
    vecs[20] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 3'd0, 3'd0}; // JALR
    vecs[21] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 3'd4, 3'd0}; // JAL

    reset = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_imem_req", mif.imem_req, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_instret", instret, 0);
    reset = 1'b0;
    #1;
    chk("release_imem_req", mif.imem_req, 1);

    // Reset in the middle of a stalled load
    @(negedge clk);
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    mif.imem_ready = 1'b1;
    @(negedge clk);
    mif.imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midmem_state", state, 3);
    chk("midmem_dmem_req", mif.dmem_req, 1);
    chk("midmem_dmem_we", mif.dmem_we, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("midmem_rst_dmem_req", mif.dmem_req, 0);
    chk("midmem_rst_state", state, 0);
    chk("midmem_rst_instret", instret, 0);
    chk("midmem_rst_rf_we", rf_we, 0);
    chk("midmem_rst_pc_load", pc_load, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midmem_post_imem_req", mif.imem_req, 1);
    chk("midmem_post_instret", instret, 0);

    for (int i = 0; i < 22; i++) run_vec(vecs[i], 0, 0);

    run_vec(vecs[10], 3, 0);   // ADDI with 3 fetch wait cycles
    run_vec(vecs[15], 0, 2);   // LW with 2 data wait cycles
    run_vec(vecs[16], 0, 1);   // SW with 1 data wait cycle
    run_vec(vecs[17], 1, 0);   // BEQ taken after one fetch wait
    run_vec(vecs[18], 0, 0);   // BNE with zero=1, not taken

    run_illegal(7'b0000000, 3'b000);
    run_vec(vecs[0], 0, 0);
    run_illegal(7'b1100011, 3'b010);
    run_vec(vecs[21], 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
